// File: rtl/pipe_stage_pkg.sv
// Shared types and constants for the elastic pipeline stage.
package pipe_stage_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } stage_state_t;

    // RISC-V canonical NOP (addi x0, x0, 0), used as the IF/ID bubble instruction.
    localparam logic [31:0] RV_NOP = 32'h00000013;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: adds a small increment each cycle, holds at all-ones.
module sat_counter #(
    parameter int unsigned CNT_WIDTH = 32,
    parameter int unsigned INC_WIDTH = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [INC_WIDTH-1:0] inc,
    output logic [CNT_WIDTH-1:0] count
);

    localparam int unsigned SUM_WIDTH = CNT_WIDTH + INC_WIDTH;

    logic [SUM_WIDTH-1:0] sum_c;
    logic [CNT_WIDTH-1:0] count_d;

    // Widened sum so overflow is visible, then clamp to all-ones.
    always_comb begin
        sum_c   = SUM_WIDTH'(count) + SUM_WIDTH'(inc);
        count_d = sum_c[CNT_WIDTH-1:0];
        if (sum_c > SUM_WIDTH'({CNT_WIDTH{1'b1}})) begin
            count_d = {CNT_WIDTH{1'b1}};
        end
    end

    // Counter register, cleared by synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else begin
            count <= count_d;
        end
    end

endmodule

// File: rtl/pipeline_stage_elastic.sv
// Elastic pipeline register: valid/ready stage with a main entry plus one skid
// entry, stall and flush, and a bubble payload whenever nothing is valid.
// Optional performance counters are enabled by defining PIPE_STAGE_PERF_EN.
module pipeline_stage_elastic
    import pipe_stage_pkg::*;
#(
    parameter int unsigned       WIDTH        = 96,
    parameter logic [WIDTH-1:0]  BUBBLE_VALUE = '0,
    parameter int unsigned       CNT_WIDTH    = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [1:0]           occupancy,
    output logic [CNT_WIDTH-1:0] perf_stall_cycles,
    output logic [CNT_WIDTH-1:0] perf_flush_kills
);

    stage_state_t     state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             in_fire;
    logic             out_fire;

    assign in_fire   = in_valid & in_ready_q;
    assign out_fire  = out_valid_q & out_ready & ~stall;

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_q;
    assign occupancy = state_q;

    // State and storage registers; in_ready/out_valid are precomputed from next state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= EMPTY;
            main_q      <= BUBBLE_VALUE;
            skid_q      <= BUBBLE_VALUE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= (state_d != FULL);
            out_valid_q <= (state_d != EMPTY);
        end
    end

    // Next-state logic; flush overrides every transfer, main falls back to the bubble.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
            main_d  = BUBBLE_VALUE;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d = ONE;
                        main_d  = in_data;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data;
                    end else if (in_fire) begin
                        state_d = FULL;
                        skid_d  = in_data;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                        main_d  = BUBBLE_VALUE;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        state_d = ONE;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    main_d  = BUBBLE_VALUE;
                end
            endcase
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    logic [1:0] stall_inc_c;
    logic [1:0] kill_inc_c;

    // Increment sources: a held valid output, and entries discarded by flush.
    always_comb begin
        stall_inc_c = {1'b0, out_valid_q & ~out_fire & ~flush};
        kill_inc_c  = flush ? occupancy : 2'd0;
    end

    sat_counter #(
        .CNT_WIDTH (CNT_WIDTH),
        .INC_WIDTH (2)
    ) u_stall_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (stall_inc_c),
        .count (perf_stall_cycles)
    );

    sat_counter #(
        .CNT_WIDTH (CNT_WIDTH),
        .INC_WIDTH (2)
    ) u_kill_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (kill_inc_c),
        .count (perf_flush_kills)
    );
`else
    assign perf_stall_cycles = CNT_WIDTH'(0);
    assign perf_flush_kills  = CNT_WIDTH'(0);
`endif

endmodule

// File: tb/tb_pipeline_stage_elastic.sv
// Scoreboard bench for pipeline_stage_elastic (IF/ID flavour, 96-bit payload).
module tb_pipeline_stage_elastic;
    import pipe_stage_pkg::*;

    localparam int unsigned WIDTH = 96;
    localparam int unsigned CW    = 4;
    localparam logic [WIDTH-1:0] BUBBLE = {RV_NOP, 64'h0};

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             stall = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       occupancy;
    logic [CW-1:0]    perf_stall_cycles;
    logic [CW-1:0]    perf_flush_kills;

    int total = 0;
    int bad   = 0;
    logic [WIDTH-1:0] exp_q[$];

    pipeline_stage_elastic #(
        .WIDTH        (WIDTH),
        .BUBBLE_VALUE (BUBBLE),
        .CNT_WIDTH    (CW)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .stall             (stall),
        .flush             (flush),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_data           (in_data),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_data          (out_data),
        .occupancy         (occupancy),
        .perf_stall_cycles (perf_stall_cycles),
        .perf_flush_kills  (perf_flush_kills)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; in_valid = 1'b0; flush = 1'b0; stall = 1'b0;
        cyc(); cyc();
        reset = 1'b0;
        exp_q.delete();
    endtask

    // Monitor: mid-cycle, decide whether the next edge transfers out and check it.
    always @(negedge clock) begin
        if (!reset) begin
            if (out_valid && out_ready && !stall) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_out: got %0h expected none", out_data);
                end else begin
                    chk("out_data", out_data, exp_q.pop_front());
                end
            end else if (out_valid === 1'b0) begin
                chk("bubble", out_data, BUBBLE);
            end
        end
    end

    initial begin
        do_reset();
        // Reset / idle state
        cyc();
        chk("rst_out_valid", WIDTH'(out_valid), WIDTH'(1'b0));
        chk("rst_out_data", out_data, BUBBLE);
        chk("rst_in_ready", WIDTH'(in_ready), WIDTH'(1'b1));
        chk("rst_occ", WIDTH'(occupancy), WIDTH'(0));
        chk("rst_perf_stall", WIDTH'(perf_stall_cycles), WIDTH'(0));
        chk("rst_perf_kill", WIDTH'(perf_flush_kills), WIDTH'(0));

        // Streaming 1..8 at full rate
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) exp_q.push_back(WIDTH'(i));
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; in_data = WIDTH'(i);
            cyc();
            chk("stream_data", out_data, WIDTH'(i));
            chk("stream_ready", WIDTH'(in_ready), WIDTH'(1'b1));
        end
        in_valid = 1'b0;
        cyc();
        chk("stream_occ_end", WIDTH'(occupancy), WIDTH'(0));
        chk("stream_drain", WIDTH'(exp_q.size()), WIDTH'(0));

        // Back-pressure with A, B, C
        exp_q.push_back(WIDTH'(96'hA)); exp_q.push_back(WIDTH'(96'hB)); exp_q.push_back(WIDTH'(96'hC));
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 96'hA; cyc();
        chk("bp_occ1", WIDTH'(occupancy), WIDTH'(1));
        chk("bp_data_a", out_data, 96'hA);
        in_data = 96'hB; cyc();
        chk("bp_occ2", WIDTH'(occupancy), WIDTH'(2));
        chk("bp_ready0", WIDTH'(in_ready), WIDTH'(1'b0));
        chk("bp_hold_a", out_data, 96'hA);
        in_data = 96'hC; cyc();
        chk("bp_occ2_hold", WIDTH'(occupancy), WIDTH'(2));
        chk("bp_hold_a2", out_data, 96'hA);
        out_ready = 1'b1; cyc();
        chk("bp_data_b", out_data, 96'hB);
        chk("bp_ready1", WIDTH'(in_ready), WIDTH'(1'b1));
        cyc();
        chk("bp_data_c", out_data, 96'hC);
        in_valid = 1'b0; cyc();
        chk("bp_occ_end", WIDTH'(occupancy), WIDTH'(0));
        chk("bp_drain", WIDTH'(exp_q.size()), WIDTH'(0));

        // Stall with occupancy 1, next input fills skid
        exp_q.push_back(WIDTH'(96'hD)); exp_q.push_back(WIDTH'(96'hE));
        in_valid = 1'b1; in_data = 96'hD; cyc();
        stall = 1'b1; in_data = 96'hE; cyc();
        chk("st_hold_d", out_data, 96'hD);
        chk("st_occ2", WIDTH'(occupancy), WIDTH'(2));
        chk("st_ready0", WIDTH'(in_ready), WIDTH'(1'b0));
        in_valid = 1'b0; cyc();
        chk("st_hold_d2", out_data, 96'hD);
        stall = 1'b0; cyc();
        chk("st_data_e", out_data, 96'hE);
        cyc();
        chk("st_occ_end", WIDTH'(occupancy), WIDTH'(0));
        chk("st_drain", WIDTH'(exp_q.size()), WIDTH'(0));

        // Reset mid-operation discards entries
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 96'h51; cyc();
        in_data = 96'h52; cyc();
        do_reset();
        chk("mr_occ", WIDTH'(occupancy), WIDTH'(0));
        chk("mr_valid", WIDTH'(out_valid), WIDTH'(1'b0));
        chk("mr_data", out_data, BUBBLE);
        out_ready = 1'b1; cyc(); cyc();

        // Flush with occupancy 2 and an input pending
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 96'hF; cyc();
        in_data = 96'h6; cyc();
        chk("fl_occ2", WIDTH'(occupancy), WIDTH'(2));
        in_data = 96'h7; flush = 1'b1; cyc();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_valid", WIDTH'(out_valid), WIDTH'(1'b0));
        chk("fl_data", out_data, BUBBLE);
        chk("fl_nop_field", WIDTH'(out_data[95:64]), WIDTH'(32'h13));
        chk("fl_occ", WIDTH'(occupancy), WIDTH'(0));
        chk("fl_ready", WIDTH'(in_ready), WIDTH'(1'b1));
`ifdef PIPE_STAGE_PERF_EN
        chk("fl_kills2", WIDTH'(perf_flush_kills), WIDTH'(2));
`else
        chk("fl_kills_off", WIDTH'(perf_flush_kills), WIDTH'(0));
`endif
        out_ready = 1'b1; cyc(); cyc();

        // Flush while delivering: J counts as delivered, simultaneous input discarded
        exp_q.push_back(WIDTH'(96'h3A));
        in_valid = 1'b1; in_data = 96'h3A; cyc();
        in_data = 96'h3B; flush = 1'b1; cyc();
        flush = 1'b0; in_valid = 1'b0;
        chk("fd_occ", WIDTH'(occupancy), WIDTH'(0));
        chk("fd_valid", WIDTH'(out_valid), WIDTH'(1'b0));
`ifdef PIPE_STAGE_PERF_EN
        chk("fd_kills3", WIDTH'(perf_flush_kills), WIDTH'(3));
`endif
        cyc(); cyc();
        chk("fd_drain", WIDTH'(exp_q.size()), WIDTH'(0));

        // Stall-cycle counter saturation over 20 held cycles
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 96'h11; cyc();
        in_valid = 1'b0;
        repeat (20) cyc();
`ifdef PIPE_STAGE_PERF_EN
        chk("sat_stall", WIDTH'(perf_stall_cycles), WIDTH'(15));
`else
        chk("sat_stall_off", WIDTH'(perf_stall_cycles), WIDTH'(0));
`endif
        chk("sat_kills", WIDTH'(perf_flush_kills), WIDTH'(0));
        chk("sat_hold", out_data, 96'h11);
        flush = 1'b1; cyc();
        flush = 1'b0; cyc();
        chk("final_drain", WIDTH'(exp_q.size()), WIDTH'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipeline_stage_elastic.md
Name: pipeline_stage_elastic

Overview:
Generic elastic pipeline register replacing the fixed-purpose stage registers (IF/ID, ID/EX, ...) with one parametrised block.
- Carries an opaque WIDTH-bit payload, for example {instruction, pc, pc_plus4} = 96 bits for IF/ID.
- Uses a valid/ready handshake with a 2-entry skid buffer, so in_ready is registered and full throughput is kept under back-pressure.
- Supports stall and flush; a flushed or empty stage presents a parametrised bubble payload (for example a NOP).

Parameters:
WIDTH, 96, payload width in bits (>=1)
BUBBLE_VALUE, '0 (WIDTH bits), out_data value whenever out_valid=0; IF/ID instance uses {32'h00000013, 64'h0}
CNT_WIDTH, 32, width of performance counters (used only with optional feature)

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
stall  input  1  hazard stall; while high, no entry leaves the stage
flush  input  1  kill all held entries this cycle
in_valid  input  1  upstream payload valid
in_ready  output  1  stage can accept; registered
in_data  input  WIDTH  upstream payload
out_valid  output  1  payload valid to downstream
out_ready  input  1  downstream accepts
out_data  output  WIDTH  payload to downstream; BUBBLE_VALUE when out_valid=0
occupancy  output  2  entries held (0..2)
perf_stall_cycles  output  CNT_WIDTH  cycles with out_valid=1 and no output transfer
perf_flush_kills  output  CNT_WIDTH  valid entries discarded by flush

Behaviour:
Reset and control:
- Single clock. reset is synchronous and active-high, sampled at posedge clock.
- Reset values: state EMPTY, out_valid=0, out_data=BUBBLE_VALUE, in_ready=1, occupancy=0, both perf counters 0.

Transfer definitions:
- in_fire = in_valid & in_ready.
- out_fire = out_valid & out_ready & !stall.

Storage and state machine:
- Storage is a main entry (drives out_*) plus one skid entry.
- States are EMPTY(0), ONE(1), FULL(2); occupancy is the state encoding.
- EMPTY: in_fire -> ONE, main<=in_data.
- ONE:
  - in_fire & out_fire -> ONE, main<=in_data.
  - in_fire & !out_fire -> FULL, skid<=in_data.
  - !in_fire & out_fire -> EMPTY, main<=BUBBLE_VALUE.
  - otherwise hold.
- FULL: out_fire -> ONE, main<=skid. in_ready=0, so no input is taken. Otherwise hold.
- in_ready next = (next state != FULL).

Timing and ordering:
- Latency in->out is 1 cycle; in_fire at cycle N gives out_valid at N+1.
- Throughput is 1 transfer per cycle when out_ready=1 and stall=0.
- Payload order is strictly FIFO; no payload is duplicated or dropped except by flush.
- out_data holds stable while out_valid=1 and no out_fire.

Stall:
- Freezes output transfer only.
- Input is still accepted while in_ready=1, filling the skid entry, after which in_ready drops.

Flush:
- Next state EMPTY, out_valid=0, out_data=BUBBLE_VALUE, in_ready=1.
- Any in_fire in the same cycle is discarded.
- Flush has priority over stall, in_fire and out_fire.
- An out_fire in the flush cycle still counts as delivered; downstream sampled it.

Reset priority:
- reset has priority over flush.
- Reset mid-operation discards all entries with no partial output.

Optional Feature:
PIPE_STAGE_PERF_EN
- Defined: two saturating CNT_WIDTH counters, both holding at all-ones with no wrap.
  - perf_stall_cycles increments when out_valid & !out_fire & !flush.
  - perf_flush_kills increments by occupancy (0, 1 or 2) when flush=1 and reset=0.
  - Both clear on reset.
- Undefined: both perf outputs tied to 0 and no counter flops are synthesised; ports remain present.

Decomposition:
- Package pipe_stage_pkg holds:
  - typedef enum logic [1:0] {EMPTY=0, ONE=1, FULL=2} stage_state_t.
  - Constant RV_NOP = 32'h00000013.
- Sub-module sat_counter (parameter CNT_WIDTH; inputs clock, reset, inc amount) is instantiated twice, only under PIPE_STAGE_PERF_EN.

Test Plan:
- Reset, then idle -> out_valid=0, out_data=BUBBLE_VALUE, in_ready=1, occupancy=0.
- Streaming: WIDTH=96 with payloads 1..8 on consecutive cycles and out_ready=1 -> outputs 1..8 on consecutive cycles, one cycle later, in order.
- Back-pressure: out_ready=0 for 3 cycles while sending A, B, C.
  - Hold phase: out_data=A, occupancy reaches 2, in_ready=0 the cycle after B is accepted, C held upstream.
  - After out_ready=1: A, B, C delivered in order with no loss.
- Stall=1 with out_ready=1 and occupancy=1 -> out_data held; the next input fills skid; after stall drops, both are delivered in order.
- Flush with occupancy=2 and in_valid=1 -> next cycle out_valid=0, out_data=BUBBLE_VALUE (32'h13 in the instruction field), occupancy=0; the flushed input never appears.
  - With PIPE_STAGE_PERF_EN: perf_flush_kills=2.
- PIPE_STAGE_PERF_EN with CNT_WIDTH=4: hold out_valid=1 and out_ready=0 for 20 cycles -> perf_stall_cycles saturates at 15.
